// File: rtl/piso_streamer.sv
// Purpose: parallel-in serial-out streamer; sends an M-bit word as M/N chunks of N bits, MS chunk first.
// Latency: chunk 0 appears the cycle after load acceptance; a word takes K ce-high cycles, and K+1 edges load-to-idle with ce held high.
// Backpressure: load_ready is high in IDLE, or on a consumed final chunk (back-to-back reload); advance is gated by ce.
module piso_streamer #(
  parameter int N = 4,
  parameter int M = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [M-1:0] parallel_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic [N-1:0] serial_out,
  output logic         out_valid,
  output logic         out_last,
  output logic         busy
);

  localparam int K  = M / N;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            at_last;
  logic            accept;

  // Handshake and status decode; load_ready depends on ce only mid-word.
  always_comb begin
    at_last    = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    load_ready = (state_q == IDLE) || (at_last && ce);
    accept     = load_valid && load_ready;
    serial_out = sr_q[M-1:M-N];
    out_valid  = (state_q == SHIFT);
    busy       = (state_q == SHIFT);
    out_last   = at_last;
  end

  // Next-state: a load wins (covers back-to-back reload), else shift or drain to IDLE on ce.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      sr_d    = parallel_in;
      cnt_d   = '0;
    end else if ((state_q == SHIFT) && ce) begin
      if (at_last) begin
        // Final chunk consumed with no follow-on word: clear so serial_out reads 0 when idle.
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end else begin
        sr_d  = sr_q << N;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset aborts any word in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_streamer.sv
// Bench for piso_streamer: directed chunk sequences on an N=4/M=16 instance, loopback on the default N=4/M=64 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A behavioural SIPO shares ce with the M=64 instance to rebuild the word.
module tb_piso_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // N=4, M=16 instance
  logic        ce, lv, lr, ov, ol, bsy;
  logic [15:0] din;
  logic [3:0]  so;

  // N=4, M=64 instance
  logic        ce64, lv64, lr64, ov64, ol64, bsy64;
  logic [63:0] din64;
  logic [3:0]  so64;
  logic [63:0] sipo_q;

  int checks = 0;
  int errors = 0;

  piso_streamer #(.N(4), .M(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .parallel_in(din), .load_valid(lv),
    .load_ready(lr), .serial_out(so), .out_valid(ov), .out_last(ol), .busy(bsy)
  );

  piso_streamer dut64 (
    .clk(clk), .rst_n(rst_n), .ce(ce64), .parallel_in(din64), .load_valid(lv64),
    .load_ready(lr64), .serial_out(so64), .out_valid(ov64), .out_last(ol64), .busy(bsy64)
  );

  // Reference SIPO: shifts in one chunk on every ce edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sipo_q <= '0;
    else if (ce64) sipo_q <= {sipo_q[59:0], so64};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of the M=16 instance: drive, check on the falling edge, then take the rising edge.
  task automatic cyc(input string tag, input logic l, input logic [15:0] d, input logic c,
                     input logic [3:0] es, input logic ev, input logic el, input logic er);
    lv = l; din = d; ce = c;
    @(negedge clk);
    check({tag, ".serial"}, 64'(so), 64'(es));
    check({tag, ".valid"},  64'(ov), 64'(ev));
    check({tag, ".busy"},   64'(bsy), 64'(ev));
    check({tag, ".last"},   64'(ol), 64'(el));
    check({tag, ".ready"},  64'(lr), 64'(er));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] word;
    int          n;
    int          ces;
    logic        done;
    logic        last_now;

    rst_n = 1'b0;
    ce = 1'b0; lv = 1'b0; din = '0;
    ce64 = 1'b0; lv64 = 1'b0; din64 = '0;
    #2;
    check("reset.serial", 64'(so), 64'h0);
    check("reset.valid",  64'(ov), 64'h0);
    check("reset.last",   64'(ol), 64'h0);
    check("reset.busy",   64'(bsy), 64'h0);
    check("reset.ready",  64'(lr), 64'h1);
    check("reset.ready64", 64'(lr64), 64'h1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, ce held high
    cyc("single.load", 1, 16'hA5C3, 1, 4'h0, 0, 0, 1);
    cyc("single.c0",   0, 16'h0000, 1, 4'hA, 1, 0, 0);
    cyc("single.c1",   0, 16'h0000, 1, 4'h5, 1, 0, 0);
    cyc("single.c2",   0, 16'h0000, 1, 4'hC, 1, 0, 0);
    cyc("single.c3",   0, 16'h0000, 1, 4'h3, 1, 1, 1);
    cyc("single.idle", 0, 16'h0000, 1, 4'h0, 0, 0, 1);

    // ce gaps 1,0,0,1,1,0,1; the load in IDLE ignores ce
    cyc("gap.load", 1, 16'hA5C3, 0, 4'h0, 0, 0, 1);
    cyc("gap.1",    0, 16'h0000, 1, 4'hA, 1, 0, 0);
    cyc("gap.2",    0, 16'h0000, 0, 4'h5, 1, 0, 0);
    cyc("gap.3",    0, 16'h0000, 0, 4'h5, 1, 0, 0);
    cyc("gap.4",    0, 16'h0000, 1, 4'h5, 1, 0, 0);
    cyc("gap.5",    0, 16'h0000, 1, 4'hC, 1, 0, 0);
    cyc("gap.6",    0, 16'h0000, 0, 4'h3, 1, 1, 0);
    cyc("gap.7",    0, 16'h0000, 1, 4'h3, 1, 1, 1);
    cyc("gap.idle", 0, 16'h0000, 1, 4'h0, 0, 0, 1);

    // Back-to-back: load_valid held with 0xBEEF
    cyc("b2b.load", 1, 16'h1234, 1, 4'h0, 0, 0, 1);
    cyc("b2b.1",    1, 16'hBEEF, 1, 4'h1, 1, 0, 0);
    cyc("b2b.2",    1, 16'hBEEF, 1, 4'h2, 1, 0, 0);
    cyc("b2b.3",    1, 16'hBEEF, 1, 4'h3, 1, 0, 0);
    cyc("b2b.4",    1, 16'hBEEF, 1, 4'h4, 1, 1, 1);
    cyc("b2b.B",    0, 16'h0000, 1, 4'hB, 1, 0, 0);
    cyc("b2b.E1",   0, 16'h0000, 1, 4'hE, 1, 0, 0);
    cyc("b2b.E2",   0, 16'h0000, 1, 4'hE, 1, 0, 0);
    cyc("b2b.F",    0, 16'h0000, 1, 4'hF, 1, 1, 1);
    cyc("b2b.idle", 0, 16'h0000, 1, 4'h0, 0, 0, 1);

    // Load offered mid-word is refused
    cyc("busy.load", 1, 16'hA5C3, 1, 4'h0, 0, 0, 1);
    cyc("busy.c0",   0, 16'h0000, 1, 4'hA, 1, 0, 0);
    cyc("busy.c1",   1, 16'hFFFF, 1, 4'h5, 1, 0, 0);
    cyc("busy.c2",   0, 16'h0000, 1, 4'hC, 1, 0, 0);
    cyc("busy.c3",   0, 16'h0000, 1, 4'h3, 1, 1, 1);
    cyc("busy.idle", 0, 16'h0000, 1, 4'h0, 0, 0, 1);

    // Reset at cnt=2 clears outputs asynchronously
    cyc("rst.load", 1, 16'h1234, 1, 4'h0, 0, 0, 1);
    cyc("rst.c0",   0, 16'h0000, 1, 4'h1, 1, 0, 0);
    cyc("rst.c1",   0, 16'h0000, 1, 4'h2, 1, 0, 0);
    lv = 1'b0; ce = 1'b1;
    @(negedge clk);
    check("rst.pre.serial", 64'(so), 64'h3);
    #1 rst_n = 1'b0;
    #1;
    check("rst.async.serial", 64'(so), 64'h0);
    check("rst.async.valid",  64'(ov), 64'h0);
    check("rst.async.last",   64'(ol), 64'h0);
    check("rst.async.ready",  64'(lr), 64'h1);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc("rst.idle1", 0, 16'h0000, 1, 4'h0, 0, 0, 1);
    cyc("rst.idle2", 0, 16'h0000, 1, 4'h0, 0, 0, 1);

    // Loopback through the SIPO with random ce on the default-size instance
    word  = 64'h0123456789ABCDEF;
    lv64  = 1'b1; din64 = word; ce64 = 1'b0;
    @(negedge clk);
    check("lb.ready", 64'(lr64), 64'h1);
    @(posedge clk); #1;
    lv64 = 1'b0; din64 = '0;
    n = 0; ces = 0; done = 1'b0;
    while (!done && n < 2000) begin
      ce64 = 1'($urandom_range(0, 1));
      @(negedge clk);
      last_now = ol64 && ce64;
      if (ce64 && ov64) ces++;
      @(posedge clk); #1;
      done = last_now;
      n++;
    end
    check("lb.done", 64'(done), 64'h1);
    check("lb.ce_cycles", 64'(ces), 64'd16);
    ce64 = 1'b0;
    @(negedge clk);
    check("lb.word", sipo_q, word);
    check("lb.valid_after", 64'(ov64), 64'h0);
    check("lb.serial_after", 64'(so64), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_streamer.md
# piso_streamer

Parallel-in, serial-out chunk streamer, the transmit counterpart of the team's SIPO chunk shift register. It accepts an M-bit word through a valid/ready load handshake and emits it as M/N consecutive N-bit chunks, most significant chunk first. Advance is gated by a shared clock enable `ce`. A SIPO with the same N, M and `ce` fed from `serial_out` holds the original word on its `parallel_out` after the last chunk is shifted in. The block sits on the transmit side of the neuron-state and weight-streaming path.

## Interface
- `N`, default 4: chunk width in bits.
- `M`, default 64: word width in bits. M must be a multiple of N and M ≥ N. K = M/N chunks per word.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ce`  in  1  chunk advance enable, shared with the downstream SIPO.
- `parallel_in`  in  M  word to send; sampled only on an accepted load.
- `load_valid`  in  1  upstream offers `parallel_in`.
- `load_ready`  out  1  block can accept a word this cycle (combinational).
- `serial_out`  out  N  current chunk (registered).
- `out_valid`  out  1  `serial_out` carries a chunk of an active word.
- `out_last`  out  1  `serial_out` is chunk K-1 of the word.
- `busy`  out  1  word in flight (equals `out_valid`).

## Operation
- State: `IDLE` or `SHIFT`. M-bit shift register `sr`. Chunk counter `cnt` of width max(1, clog2(K)).
- `serial_out` = `sr[M-1:M-N]` at all times.
- `load_ready` = (`IDLE`) OR (`SHIFT` AND `ce` AND `cnt`==K-1).
- The load is accepted on an edge where `load_valid` AND `load_ready` are both high. On acceptance: `sr` ← `parallel_in`, `cnt` ← 0, state ← `SHIFT`. In `IDLE` the load does not depend on `ce`.
- `SHIFT` with `ce`=1 and `cnt`<K-1: `sr` ← `sr` << N (zero fill), `cnt` ← `cnt`+1.
- `SHIFT` with `ce`=1 and `cnt`==K-1: the final chunk is consumed.
  - With an accepted load (back-to-back): reload and stay in `SHIFT` with no bubble.
  - Otherwise: `sr` ← 0, `cnt` ← 0, state ← `IDLE`.
- `SHIFT` with `ce`=0: all state holds.
- `load_valid` during `SHIFT` outside the final-chunk cycle is not accepted. `parallel_in` is ignored and the word in flight is unaffected.
- `out_valid` = `busy` = (state==`SHIFT`). `out_last` = `SHIFT` AND `cnt`==K-1.
- K=1: every `ce` cycle in `SHIFT` is the final chunk. `out_last` = `out_valid`.

## Timing
- Reset state: `sr`=0, `cnt`=0, `IDLE`. Outputs during reset: `serial_out`=0, `out_valid`=0, `out_last`=0, `busy`=0, `load_ready`=1.
- Reset asserted mid-word aborts the word immediately and asynchronously. No partial chunks follow deassertion.
- Load accepted at edge t: chunk 0 (`parallel_in[M-1:M-N]`) appears on `serial_out` after t, with `out_valid`=1.
- Chunk i is presented until the edge at which `ce`=1. The downstream SIPO captures it on that same edge.
- A word occupies exactly K `ce`-high cycles. With `ce` held high, the load-to-idle latency is K+1 edges.
- `IDLE` is entered after the final consumed chunk, with `serial_out` reading 0.
- Back-to-back throughput with `ce` held high is one word per K cycles.

## Test plan
- Single word: N=4, M=16, load 0xA5C3, `ce`=1 → `serial_out` shows A,5,C,3 on four consecutive cycles. `out_last` is high only on 3. The cycle after that: `out_valid`=0, `serial_out`=0, `load_ready`=1.
- `ce` gaps: same word, `ce` pattern 1,0,0,1,1,0,1 → each chunk holds through the `ce`=0 cycles. Exactly four `ce`-high cycles complete the word.
- Back-to-back: load 0x1234 and hold `load_valid` with 0xBEEF presented on the final-chunk cycle → output 1,2,3,4,B,E,E,F with no bubble. `out_last` is high on 4 and on F.
- Load while busy: `load_valid`=1 with 0xFFFF at `cnt`=1 → not accepted. The stream continues unchanged.
- Reset mid-word: assert `rst_n`=0 at `cnt`=2 → `out_valid`, `out_last` and `serial_out` go to 0 immediately. After release, the block is idle with `load_ready`=1.
- Loopback with defaults N=4, M=64: connect `serial_out` to a SIPO with shared `ce`. Send 0x0123456789ABCDEF with random `ce` → SIPO `parallel_out` equals 0x0123456789ABCDEF on the cycle after `out_last` is consumed.
